// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC and fetch FSM states
package fetch_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int ILEN = 32;
   typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode handshake signals of the fetch stage
interface fetch_if #(parameter int XLEN = fetch_pkg::XLEN_DEF);
   import fetch_pkg::*;
   logic redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic imem_req, imem_gnt, imem_rvalid;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic id_valid, id_ready;
   logic [XLEN-1:0] id_pc;
   logic [ILEN-1:0] id_instr;
   modport master (
      input redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_pc, id_instr
   );
   modport slave (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input imem_req, imem_addr, id_valid, id_pc, id_instr
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry in-order FIFO with synchronous flush and occupancy count
module fetch_fifo #(parameter int W = 64) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic wp, rp;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (rst || flush) begin
         wp <= 1'b0;
         rp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-outstanding imem fetch and 2-entry decode buffer.
// Defining FETCH_STALL_CNT_EN adds stall_cnt, a saturating count of decode back-pressure cycles.
module fetch_stage import fetch_pkg::*; #(
   parameter int XLEN = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input logic clk,
   input logic rst,
   fetch_if.master bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [XLEN-1:0] stall_cnt
`endif
);
   fetch_state_e state;
   logic [XLEN-1:0] pc, req_pc;
   logic outstanding, gnt, rsp, push, pop;
   logic [1:0] count;
   logic [XLEN+ILEN-1:0] head;
   // one FIFO slot is reserved for every request in flight, so a push never finds it full
   assign bus.imem_req = !rst && state == RUN && !outstanding && 3'(count) + 3'(outstanding) < 3'd2;
   assign bus.imem_addr = pc;
   assign bus.id_valid = count != 2'd0;
   assign {bus.id_pc, bus.id_instr} = head;
   assign gnt = bus.imem_req && bus.imem_gnt;
   assign rsp = bus.imem_rvalid && outstanding;
   assign push = rsp && state == RUN && !bus.redirect_valid;
   assign pop = bus.id_valid && bus.id_ready && !bus.redirect_valid;
   fetch_fifo #(.W(XLEN + ILEN)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(bus.redirect_valid),
      .push(push),
      .pop(pop),
      .din({req_pc, bus.imem_rdata}),
      .dout(head),
      .count(count)
   );
   always_ff @(posedge clk)
      if (rst) begin
         pc <= RESET_PC;
         req_pc <= '0;
         outstanding <= 1'b0;
         state <= RUN;
      end else begin
         pc <= bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : gnt ? pc + XLEN'(4) : pc;
         if (gnt) req_pc <= pc;
         outstanding <= gnt || (outstanding && !bus.imem_rvalid);
         // a response still owed to the old path must be swallowed before fetching resumes
         state <= (bus.redirect_valid && (gnt || (outstanding && !bus.imem_rvalid))) ||
                  (state == DRAIN && !rsp) ? DRAIN : RUN;
      end
`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk)
      if (rst) stall_cnt <= '0;
      else if (bus.id_valid && !bus.id_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + XLEN'(1);
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random imem/decode traffic against an in-order instruction-stream model
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic clk, rst;
   fetch_if #(.XLEN(32)) bus();
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int vectors = 0, errors = 0;
   int gnt_p = 100, rdy_p = 100, lat_min = 1, lat_max = 1;
   logic [31:0] exp_pc = RESET_PC, maddr = '0;
   bit pend = 0, prev_rst = 0, prev_redir = 0;
   int lat = 0;
   logic [31:0] issued[$], seen[$];
   function automatic logic [31:0] memf(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction
   task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic drive(bit r, bit redir, logic [31:0] rpc);
      rst = r;
      bus.redirect_valid = redir;
      bus.redirect_pc = rpc;
      bus.imem_gnt = $urandom_range(99) < gnt_p;
      bus.id_ready = $urandom_range(99) < rdy_p;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
      if (pend) begin
         lat--;
         if (lat == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = memf(maddr);
            pend = 0;
         end
      end
   endtask
   // the decode side must see one unbroken sequential stream from the last reset/redirect target
   task automatic sample();
      if (rst) begin
         check("req_in_rst", bus.imem_req, 0);
         pend = 0;
         exp_pc = RESET_PC;
      end else begin
         if (prev_rst) begin
            check("rst_valid", bus.id_valid, 0);
            check("rst_addr", bus.imem_addr, RESET_PC);
         end
         if (prev_redir) check("flush", bus.id_valid, 0);
         if (bus.imem_req) check("addr_align", bus.imem_addr[1:0], 0);
         if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
            check("id_pc", bus.id_pc, exp_pc);
            check("id_instr", bus.id_instr, memf(exp_pc));
            seen.push_back(bus.id_pc);
            exp_pc += 32'd4;
         end
         if (bus.imem_req && bus.imem_gnt) begin
            check("gnt_while_busy", pend, 0);
            pend = 1;
            maddr = bus.imem_addr;
            lat = $urandom_range(lat_max, lat_min);
            issued.push_back(bus.imem_addr);
         end
         if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end
      prev_rst = rst;
      prev_redir = bus.redirect_valid && !rst;
   endtask
   task automatic cyc(bit r = 0, bit redir = 0, logic [31:0] rpc = '0);
      drive(r, redir, rpc);
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask
   task automatic setup(int g, int rd, int lmin, int lmax);
      gnt_p = g;
      rdy_p = rd;
      lat_min = lmin;
      lat_max = lmax;
   endtask
   initial begin
      int n, hits;
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = '0;
      bus.id_ready = 1'b0;
      @(posedge clk);
      #1;
      setup(100, 100, 1, 1);
      repeat (2) cyc(1);
      issued.delete();
      seen.delete();
      repeat (10) cyc();
      for (int i = 0; i < 3; i++) begin
         check("seq_addr", issued[i], 32'(4 * i));
         check("seq_pc", seen[i], 32'(4 * i));
      end
      setup(100, 0, 1, 1);
      cyc(1);
      seen.delete();
      repeat (12) cyc();
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", stall_cnt, 10);
`endif
      check("full_req", bus.imem_req, 0);
      check("full_valid", bus.id_valid, 1);
      rdy_p = 100;
      repeat (8) cyc();
      for (int i = 0; i < 3; i++) check("drain_pc", seen[i], 32'(4 * i));
      setup(100, 100, 3, 3);
      cyc(1);
      issued.delete();
      seen.delete();
      for (int i = 0; i < 40 && !(issued.size() > 0 && issued[$] == 32'h8); i++) cyc();
      check("reach_8", issued[$], 32'h8);
      cyc(0, 1, 32'h100);
      n = seen.size();
      repeat (20) cyc();
      check("redir_pc", seen[n], 32'h100);
      hits = 0;
      foreach (seen[i]) if (seen[i] == 32'h8) hits++;
      check("drop_8", hits, 0);
      setup(100, 100, 1, 2);
      cyc(0, 1, 32'h203);
      n = issued.size();
      repeat (10) cyc();
      check("align_addr", issued[n], 32'h200);
      cyc(0, 1, 32'hFFFF_FFFC);
      n = issued.size();
      repeat (12) cyc();
      check("wrap_last", issued[n], 32'hFFFF_FFFC);
      check("wrap_zero", issued[n + 1], 32'h0);
      setup(100, 0, 3, 3);
      cyc(1);
      issued.delete();
      for (int i = 0; i < 30 && issued.size() < 2; i++) cyc();
      check("busy_before_rst", pend, 1);
      check("entry_before_rst", bus.id_valid, 1);
      cyc(1);
      check("mid_rst_valid", bus.id_valid, 0);
      check("mid_rst_addr", bus.imem_addr, RESET_PC);
      setup(70, 60, 1, 3);
      n = seen.size();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = $urandom_range(9) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : ($urandom & 32'h0000_FFFF);
         cyc($urandom_range(199) == 0, $urandom_range(19) == 0, rpc);
      end
      check("progress", seen.size() - n > 100, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
